pipe_stall_ctrl: RTL and testbench

- Consumer side of the RAW hazard-detection request in the 5-stage pipeline.
- Converts the level hazard request into an exact number of front-end hold cycles. Holds the PC and the IF/ID register for that number of cycles and injects bubbles into ID/EX.
- Also sequences branch/jump flushes and the createdump halt.
- Replaces the one-cycle pulse trick in the hazard unit with a proper counter and FSM. Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Front-end hold sequencer: turns the level RAW hazard request into an exact
// number of PC / IF-ID hold cycles with ID/EX bubbles, plus flush and halt.
module pipe_stall_ctrl #(
    parameter int CNT_W     = 2,
    parameter int MAX_STALL = 3,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_req,
    input  logic [CNT_W-1:0]  stall_len,
    input  logic              flush_req,
    input  logic              halt_req,
    output logic              pc_wr_en,
    output logic              if_id_wr_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_remaining,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_L    = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0]  ONE_L    = CNT_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_len_eff;
    logic [PERF_W-1:0]  r_stall_cycles;

    assign w_len_eff = (stall_len > MAX_L) ? MAX_L : stall_len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (stall_active && (r_stall_cycles != PERF_MAX))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    // r_cnt holds the hold cycles still owed after the cycle that loaded it.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        pc_wr_en        = 1'b1;
        if_id_wr_en     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        stall_active    = 1'b0;
        stall_remaining = '0;
        halted          = 1'b0;

        case (r_state)
            IDLE: begin
                if (halt_req) begin
                    pc_wr_en     = 1'b0;
                    if_id_wr_en  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = HALT;
                end else if (flush_req) begin
                    if_id_flush = 1'b1;
                    w_cnt_next  = '0;
                end else if (stall_req && (w_len_eff != '0)) begin
                    pc_wr_en        = 1'b0;
                    if_id_wr_en     = 1'b0;
                    id_ex_bubble    = 1'b1;
                    stall_active    = 1'b1;
                    stall_remaining = w_len_eff - 1'b1;
                    w_cnt_next      = w_len_eff - 1'b1;
                    w_state_next    = (w_len_eff > ONE_L) ? STALL : IDLE;
                end
            end

            STALL: begin
                if (halt_req) begin
                    pc_wr_en     = 1'b0;
                    if_id_wr_en  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = HALT;
                end else if (flush_req) begin
                    // The stalled instruction is being killed; the hold is moot.
                    if_id_flush  = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else begin
                    pc_wr_en        = 1'b0;
                    if_id_wr_en     = 1'b0;
                    id_ex_bubble    = 1'b1;
                    stall_active    = 1'b1;
                    stall_remaining = r_cnt - 1'b1;
                    w_cnt_next      = r_cnt - 1'b1;
                    if (r_cnt == ONE_L)
                        w_state_next = IDLE;
                end
            end

            HALT: begin
                pc_wr_en     = 1'b0;
                if_id_wr_en  = 1'b0;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Reset forces a safe front end regardless of state.
        if (!rst) begin
            pc_wr_en        = 1'b0;
            if_id_wr_en     = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_bubble    = 1'b1;
            stall_active    = 1'b0;
            stall_remaining = '0;
            halted          = 1'b0;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (MAX_STALL 3 and 2) against a
// cycle-level model tracking owed hold cycles, halt flag and stall count.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_req = 1'b0;
    logic [1:0]  stall_len = 2'd0;
    logic        flush_req = 1'b0;
    logic        halt_req = 1'b0;

    logic        pc_a, ifid_a, fl_a, bub_a, sa_a, hl_a;
    logic [1:0]  rem_a;
    logic [15:0] sc_a;
    logic        pc_b, ifid_b, fl_b, bub_b, sa_b, hl_b;
    logic [1:0]  rem_b;
    logic [15:0] sc_b;

    int errors = 0;
    int checks = 0;

    int hold_left [2];
    int halted_m  [2];
    int perf      [2];
    int max_l     [2] = '{3, 2};

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(2), .MAX_STALL(3), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .stall_len(stall_len),
        .flush_req(flush_req), .halt_req(halt_req),
        .pc_wr_en(pc_a), .if_id_wr_en(ifid_a), .if_id_flush(fl_a),
        .id_ex_bubble(bub_a), .stall_active(sa_a), .stall_remaining(rem_a),
        .halted(hl_a), .stall_cycles(sc_a)
    );

    pipe_stall_ctrl #(.CNT_W(2), .MAX_STALL(2), .PERF_W(16)) dut2 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .stall_len(stall_len),
        .flush_req(flush_req), .halt_req(halt_req),
        .pc_wr_en(pc_b), .if_id_wr_en(ifid_b), .if_id_flush(fl_b),
        .id_ex_bubble(bub_b), .stall_active(sa_b), .stall_remaining(rem_b),
        .halted(hl_b), .stall_cycles(sc_b)
    );

    task automatic drive(input logic r, input logic sr, input int len,
                         input logic fl, input logic ht);
        rst       = r;
        stall_req = sr;
        stall_len = 2'(len);
        flush_req = fl;
        halt_req  = ht;
    endtask

    // One clock: compare both instances mid-cycle, then advance the model.
    task automatic step(input string tag);
        int L, rem;
        logic pc, ifid, fl, bub, sa, hl;
        logic [24:0] exp_v, obs_v;
        int nh [2];
        int nt [2];
        int np [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            L = (int'(stall_len) > max_l[k]) ? max_l[k] : int'(stall_len);
            pc = 1; ifid = 1; fl = 0; bub = 0; sa = 0; hl = 0; rem = 0;
            nh[k] = hold_left[k]; nt[k] = halted_m[k]; np[k] = perf[k];
            if (!rst) begin
                pc = 0; ifid = 0; fl = 1; bub = 1;
                nh[k] = 0; nt[k] = 0; np[k] = 0;
            end else if (halted_m[k] != 0) begin
                pc = 0; ifid = 0; bub = 1; hl = 1;
            end else if (halt_req) begin
                pc = 0; ifid = 0; bub = 1;
                nt[k] = 1; nh[k] = 0;
            end else if (flush_req) begin
                fl = 1; nh[k] = 0;
            end else if (hold_left[k] > 0) begin
                pc = 0; ifid = 0; bub = 1; sa = 1;
                rem = hold_left[k] - 1; nh[k] = hold_left[k] - 1;
            end else if (stall_req && L > 0) begin
                pc = 0; ifid = 0; bub = 1; sa = 1;
                rem = L - 1; nh[k] = L - 1;
            end
            if (sa && np[k] < 65535) np[k] = np[k] + 1;
            exp_v = {pc, ifid, fl, bub, sa, 2'(rem), hl, 16'(perf[k])};
            if (k == 0) obs_v = {pc_a, ifid_a, fl_a, bub_a, sa_a, rem_a, hl_a, sc_a};
            else        obs_v = {pc_b, ifid_b, fl_b, bub_b, sa_b, rem_b, hl_b, sc_b};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s dut%0d observed=%h expected=%h (pc,ifid,flush,bub,sa,rem,halt,cnt)",
                       tag, k, obs_v, exp_v);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            hold_left[k] = nh[k];
            halted_m[k]  = nt[k];
            perf[k]      = np[k];
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step("reset");
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hold_left[k] = 0; halted_m[k] = 0; perf[k] = 0;
        end
        // First edge clears DUT state; model already starts cleared.
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset(2);
        $display("phase reset: checks=%0d errors=%0d", checks, errors);

        // Single-cycle hold from a one-cycle request of length 1.
        drive(1, 1, 1, 0, 0); step("len1_hold");
        drive(1, 0, 0, 0, 0); step("len1_after"); step("len1_idle");
        $display("phase len1: checks=%0d errors=%0d", checks, errors);

        // Length 3 pulse; re-asserted request during hold adds nothing.
        drive(1, 1, 3, 0, 0); step("len3_c1");
        drive(1, 1, 2, 0, 0); step("len3_c2"); step("len3_c3");
        drive(1, 0, 0, 0, 0); step("len3_after"); step("len3_idle");
        $display("phase len3: checks=%0d errors=%0d", checks, errors);

        // Zero length is no stall; length 3 clamps to 2 on the second instance.
        drive(1, 1, 0, 0, 0); step("len0");
        drive(1, 1, 3, 0, 0); step("clamp_c1");
        drive(1, 0, 0, 0, 0); step("clamp_c2"); step("clamp_c3"); step("clamp_idle");
        $display("phase clamp: checks=%0d errors=%0d", checks, errors);

        // Flush on the second hold cycle aborts the stall.
        do_reset(1);
        drive(1, 1, 3, 0, 0); step("abort_c1");
        drive(1, 0, 0, 1, 0); step("abort_flush");
        drive(1, 0, 0, 0, 0); step("abort_idle");
        checks++;
        assert (sc_a === 16'd1) else begin
            errors++;
            $error("FAIL abort_count observed=%0d expected=1", sc_a);
        end
        $display("phase flush_abort: checks=%0d errors=%0d", checks, errors);

        // Halt with simultaneous flush, then sticky under varied inputs.
        drive(1, 0, 0, 1, 1); step("halt_entry");
        for (int i = 0; i < 6; i++) begin
            drive(1, i[0], i % 4, i[1], 0);
            step("halt_sticky");
        end
        $display("phase halt: checks=%0d errors=%0d", checks, errors);

        // Reset during the second cycle of a 3-cycle hold.
        do_reset(1);
        drive(1, 1, 3, 0, 0); step("rstmid_c1");
        drive(0, 0, 0, 0, 0); step("rstmid_rst");
        drive(1, 0, 0, 0, 0); step("rstmid_idle"); step("rstmid_idle2");
        checks++;
        assert (sc_a === 16'd0) else begin
            errors++;
            $error("FAIL rstmid_count observed=%0d expected=0", sc_a);
        end
        $display("phase reset_mid_stall: checks=%0d errors=%0d", checks, errors);

        // Randomized traffic with occasional reset so halt does not dominate.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 39) != 0),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 99) == 0));
            step("random");
        end
        $display("phase random: checks=%0d errors=%0d", checks, errors);

        // Continuous hazard to drive the counter into saturation.
        do_reset(1);
        drive(1, 1, 3, 0, 0);
        for (int i = 0; i < 70000; i++) step("saturate");
        drive(1, 0, 0, 0, 0);
        step("saturate_end");
        checks++;
        assert (sc_a === 16'hFFFF) else begin
            errors++;
            $error("FAIL saturate_count observed=%0d expected=65535", sc_a);
        end
        $display("phase saturate: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
